// File: rtl/sgdmac_desc_queue.sv
// Descriptor queue between the SG-DMA descriptor fetcher and the transfer engine.
// First-word-fall-through circular buffer with drop/overflow/byte accounting.
module sgdmac_desc_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wren_i,
    input  logic [47:0]      wdata_i,
    input  logic             rw_i,
    input  logic             clr_i,
    output logic             desc_valid_o,
    input  logic             desc_ready_i,
    output logic [31:0]      desc_addr_o,
    output logic [15:0]      desc_len_o,
    output logic             desc_rw_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o,
    output logic [7:0]       drop_cnt_o,
    output logic [31:0]      bytes_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sgdmac_desc_queue: DEPTH must be a power of two in 2..16");
    end

    // Entry layout: {rw, addr[31:0], len[15:0]}
    logic [48:0]      mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [31:0]      bytes_q, bytes_d;

    logic             len_nz;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [48:0]      head;

    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == '0);
    assign len_nz = (wdata_i[15:0] != 16'h0000);
    assign head   = mem[rd_ptr_q];

    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign pop  = !empty && desc_ready_i;
    assign push = wren_i && len_nz && (!full || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        bytes_d    = bytes_q;

        if (clr_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            bytes_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                bytes_d  = bytes_q + {16'h0000, head[15:0]};
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (wren_i && len_nz && full && !pop) begin
                overflow_d = 1'b1;
            end
            if (wren_i && !len_nz && drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            bytes_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
            bytes_q    <= bytes_d;
        end
    end

    // Storage is not reset; entries are only observable once counted in.
    always_ff @(posedge clk) begin
        if (push && !clr_i && !rst) begin
            mem[wr_ptr_q] <= {rw_i, wdata_i};
        end
    end

    assign desc_valid_o = !empty;
    assign desc_rw_o    = head[48];
    assign desc_addr_o  = head[47:16];
    assign desc_len_o   = head[15:0];
    assign count_o      = count_q;
    assign full_o       = full;
    assign empty_o      = empty;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;
    assign bytes_o      = bytes_q;

endmodule

// File: tb/tb_sgdmac_desc_queue.sv
// Directed self-checking bench for sgdmac_desc_queue at DEPTH=4.
module tb_sgdmac_desc_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             wren_i;
    logic [47:0]      wdata_i;
    logic             rw_i;
    logic             clr_i;
    logic             desc_valid_o;
    logic             desc_ready_i;
    logic [31:0]      desc_addr_o;
    logic [15:0]      desc_len_o;
    logic             desc_rw_o;
    logic [CNT_W-1:0] count_o;
    logic             full_o;
    logic             empty_o;
    logic             overflow_o;
    logic [7:0]       drop_cnt_o;
    logic [31:0]      bytes_o;

    int tests_run = 0;
    int failed    = 0;

    sgdmac_desc_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wren_i       (wren_i),
        .wdata_i      (wdata_i),
        .rw_i         (rw_i),
        .clr_i        (clr_i),
        .desc_valid_o (desc_valid_o),
        .desc_ready_i (desc_ready_i),
        .desc_addr_o  (desc_addr_o),
        .desc_len_o   (desc_len_o),
        .desc_rw_o    (desc_rw_o),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o),
        .bytes_o      (bytes_o)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] addr, input logic [15:0] len, input logic rw);
        wren_i  = 1'b1;
        wdata_i = {addr, len};
        rw_i    = rw;
        tick();
        wren_i  = 1'b0;
    endtask

    task automatic do_clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests_run++; if (count_o !== 3'd0) begin failed++; $display("FAIL reset_count got %0d want 0", count_o); end
        tests_run++; if (empty_o !== 1'b1) begin failed++; $display("FAIL reset_empty got %b want 1", empty_o); end
        tests_run++; if (full_o !== 1'b0) begin failed++; $display("FAIL reset_full got %b want 0", full_o); end
        tests_run++; if (desc_valid_o !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", desc_valid_o); end
        tests_run++; if (overflow_o !== 1'b0) begin failed++; $display("FAIL reset_overflow got %b want 0", overflow_o); end
        tests_run++; if (drop_cnt_o !== 8'd0) begin failed++; $display("FAIL reset_drop got %0d want 0", drop_cnt_o); end
        tests_run++; if (bytes_o !== 32'd0) begin failed++; $display("FAIL reset_bytes got %h want 0", bytes_o); end
    endtask

    task automatic test_basic();
        desc_ready_i = 1'b0;
        push(32'h1000_0000, 16'h0040, 1'b1);
        tests_run++; if (desc_valid_o !== 1'b1) begin failed++; $display("FAIL basic_valid got %b want 1", desc_valid_o); end
        tests_run++; if (desc_addr_o !== 32'h1000_0000) begin failed++; $display("FAIL basic_addr got %h want 10000000", desc_addr_o); end
        tests_run++; if (desc_len_o !== 16'h0040) begin failed++; $display("FAIL basic_len got %h want 0040", desc_len_o); end
        tests_run++; if (desc_rw_o !== 1'b1) begin failed++; $display("FAIL basic_rw got %b want 1", desc_rw_o); end
        tests_run++; if (count_o !== 3'd1) begin failed++; $display("FAIL basic_count got %0d want 1", count_o); end
        tick();
        tests_run++; if (desc_addr_o !== 32'h1000_0000 || desc_valid_o !== 1'b1) begin failed++; $display("FAIL basic_hold got %h/%b want 10000000/1", desc_addr_o, desc_valid_o); end
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
        tests_run++; if (bytes_o !== 32'h40) begin failed++; $display("FAIL basic_bytes got %h want 40", bytes_o); end
        tests_run++; if (empty_o !== 1'b1 || desc_valid_o !== 1'b0) begin failed++; $display("FAIL basic_empty got %b/%b want 1/0", empty_o, desc_valid_o); end
    endtask

    task automatic test_no_bypass();
        do_clear();
        desc_ready_i = 1'b1;
        push(32'h0000_0ABC, 16'h0010, 1'b0);
        tests_run++; if (count_o !== 3'd1) begin failed++; $display("FAIL nobypass_count got %0d want 1", count_o); end
        tests_run++; if (bytes_o !== 32'd0) begin failed++; $display("FAIL nobypass_bytes0 got %h want 0", bytes_o); end
        tests_run++; if (desc_rw_o !== 1'b0) begin failed++; $display("FAIL nobypass_rw got %b want 0", desc_rw_o); end
        tick();
        desc_ready_i = 1'b0;
        tests_run++; if (count_o !== 3'd0 || bytes_o !== 32'h10) begin failed++; $display("FAIL nobypass_pop got %0d/%h want 0/10", count_o, bytes_o); end
    endtask

    task automatic test_overflow();
        do_clear();
        desc_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h0000_0100 + i, 16'(i + 1), i[0]);
        end
        tests_run++; if (count_o !== 3'd4 || full_o !== 1'b1) begin failed++; $display("FAIL ovf_full got %0d/%b want 4/1", count_o, full_o); end
        tests_run++; if (overflow_o !== 1'b0) begin failed++; $display("FAIL ovf_early got %b want 0", overflow_o); end
        push(32'h0000_0999, 16'h0005, 1'b1);
        tests_run++; if (overflow_o !== 1'b1) begin failed++; $display("FAIL ovf_set got %b want 1", overflow_o); end
        tests_run++; if (count_o !== 3'd4) begin failed++; $display("FAIL ovf_count got %0d want 4", count_o); end
        desc_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (desc_addr_o !== 32'h0000_0100 + i || desc_len_o !== 16'(i + 1) || desc_rw_o !== i[0]) begin
                failed++;
                $display("FAIL ovf_pop%0d got %h/%h/%b want %h/%h/%b", i, desc_addr_o, desc_len_o,
                         desc_rw_o, 32'h100 + i, 16'(i + 1), i[0]);
            end
            tick();
        end
        desc_ready_i = 1'b0;
        tests_run++; if (empty_o !== 1'b1 || overflow_o !== 1'b1) begin failed++; $display("FAIL ovf_sticky got %b/%b want 1/1", empty_o, overflow_o); end
        tests_run++; if (bytes_o !== 32'd10) begin failed++; $display("FAIL ovf_bytes got %0d want 10", bytes_o); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_addr [4];
        logic [15:0] exp_len  [4];
        exp_addr[0] = 32'h201; exp_addr[1] = 32'h202; exp_addr[2] = 32'h203; exp_addr[3] = 32'h2FF;
        exp_len[0]  = 16'h11;  exp_len[1]  = 16'h12;  exp_len[2]  = 16'h13;  exp_len[3]  = 16'h77;
        do_clear();
        desc_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h200 + i, 16'h10 + 16'(i), 1'b0);
        end
        desc_ready_i = 1'b1;
        push(32'h2FF, 16'h77, 1'b1);
        desc_ready_i = 1'b0;
        tests_run++; if (count_o !== 3'd4 || full_o !== 1'b1) begin failed++; $display("FAIL fpp_count got %0d/%b want 4/1", count_o, full_o); end
        tests_run++; if (overflow_o !== 1'b0) begin failed++; $display("FAIL fpp_overflow got %b want 0", overflow_o); end
        tests_run++; if (bytes_o !== 32'h10) begin failed++; $display("FAIL fpp_bytes got %h want 10", bytes_o); end
        desc_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (desc_addr_o !== exp_addr[i] || desc_len_o !== exp_len[i]) begin
                failed++;
                $display("FAIL fpp_pop%0d got %h/%h want %h/%h", i, desc_addr_o, desc_len_o,
                         exp_addr[i], exp_len[i]);
            end
            tick();
        end
        desc_ready_i = 1'b0;
        tests_run++; if (empty_o !== 1'b1) begin failed++; $display("FAIL fpp_empty got %b want 1", empty_o); end
    endtask

    task automatic test_zero_len();
        do_clear();
        desc_ready_i = 1'b0;
        push(32'h300, 16'h0008, 1'b0);
        push(32'h301, 16'h0000, 1'b1);
        tests_run++; if (count_o !== 3'd1) begin failed++; $display("FAIL zl_count got %0d want 1", count_o); end
        tests_run++; if (drop_cnt_o !== 8'd1) begin failed++; $display("FAIL zl_drop1 got %0d want 1", drop_cnt_o); end
        for (int i = 0; i < 299; i++) begin
            push(32'h400 + i, 16'h0000, 1'b0);
        end
        tests_run++; if (drop_cnt_o !== 8'd255) begin failed++; $display("FAIL zl_sat got %0d want 255", drop_cnt_o); end
        tests_run++; if (count_o !== 3'd1 || desc_addr_o !== 32'h300) begin failed++; $display("FAIL zl_head got %0d/%h want 1/300", count_o, desc_addr_o); end
    endtask

    task automatic test_clear();
        do_clear();
        desc_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'h500 + i, 16'h0020, 1'b0);
        end
        push(32'h5FF, 16'h0000, 1'b0);
        desc_ready_i = 1'b1;
        tick();
        desc_ready_i = 1'b0;
        tests_run++; if (count_o !== 3'd3 || overflow_o !== 1'b1 || bytes_o !== 32'h20 || drop_cnt_o !== 8'd1) begin
            failed++; $display("FAIL clr_setup got %0d/%b/%h/%0d want 3/1/20/1", count_o, overflow_o, bytes_o, drop_cnt_o);
        end
        clr_i        = 1'b1;
        desc_ready_i = 1'b1;
        push(32'h600, 16'h0030, 1'b1);
        clr_i        = 1'b0;
        desc_ready_i = 1'b0;
        tests_run++; if (count_o !== 3'd0 || desc_valid_o !== 1'b0) begin failed++; $display("FAIL clr_count got %0d/%b want 0/0", count_o, desc_valid_o); end
        tests_run++; if (bytes_o !== 32'd0 || overflow_o !== 1'b0 || drop_cnt_o !== 8'd0) begin
            failed++; $display("FAIL clr_status got %h/%b/%0d want 0/0/0", bytes_o, overflow_o, drop_cnt_o);
        end
        tick();
        tests_run++; if (empty_o !== 1'b1) begin failed++; $display("FAIL clr_push_lost got %b want 1", empty_o); end
    endtask

    task automatic test_mid_reset();
        do_clear();
        desc_ready_i = 1'b0;
        push(32'h700, 16'h0004, 1'b0);
        push(32'h701, 16'h0004, 1'b0);
        rst          = 1'b1;
        desc_ready_i = 1'b1;
        push(32'h702, 16'h0004, 1'b0);
        rst          = 1'b0;
        desc_ready_i = 1'b0;
        tests_run++; if (count_o !== 3'd0 || desc_valid_o !== 1'b0 || bytes_o !== 32'd0) begin
            failed++; $display("FAIL midrst got %0d/%b/%h want 0/0/0", count_o, desc_valid_o, bytes_o);
        end
        tick();
        tests_run++; if (empty_o !== 1'b1) begin failed++; $display("FAIL midrst_empty got %b want 1", empty_o); end
    endtask

    task automatic test_bytes_wrap();
        int n;
        do_clear();
        desc_ready_i = 1'b0;
        push(32'h800, 16'hFFFF, 1'b0);
        push(32'h801, 16'hFFFF, 1'b0);
        desc_ready_i = 1'b1;
        tick();
        tick();
        desc_ready_i = 1'b0;
        tests_run++; if (bytes_o !== 32'h0001_FFFE) begin failed++; $display("FAIL wrap_two got %h want 0001fffe", bytes_o); end
        do_clear();
        desc_ready_i = 1'b1;
        wren_i       = 1'b1;
        wdata_i      = {32'h900, 16'hFFFF};
        rw_i         = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            tick();
        end
        wren_i = 1'b0;
        n = 0;
        while (!empty_o && n < 8) begin
            tick();
            n++;
        end
        tests_run++; if (empty_o !== 1'b1) begin failed++; $display("FAIL wrap_drain got %b want 1", empty_o); end
        tests_run++; if (bytes_o !== 32'hFFFF_FFFF) begin failed++; $display("FAIL wrap_preload got %h want ffffffff", bytes_o); end
        push(32'h901, 16'hFFFF, 1'b0);
        tick();
        desc_ready_i = 1'b0;
        tests_run++; if (bytes_o !== 32'h0000_FFFE) begin failed++; $display("FAIL wrap_mod got %h want 0000fffe", bytes_o); end
    endtask

    initial begin
        rst          = 1'b1;
        wren_i       = 1'b0;
        wdata_i      = '0;
        rw_i         = 1'b0;
        clr_i        = 1'b0;
        desc_ready_i = 1'b0;
        test_reset();
        test_basic();
        test_no_bypass();
        test_overflow();
        test_full_push_pop();
        test_zero_len();
        test_clear();
        test_mid_reset();
        test_bytes_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
